// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary source and the bin_to_bcd_seq converter.
// W is the width of the binary operand.
interface bin_to_bcd_seq_if #(
  parameter int W = 10
);
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   ones;
  logic [3:0]   tens;
  logic [3:0]   hundreds;
  logic         ovf;

  modport master (
    output start, bin,
    input  busy, done, ones, tens, hundreds, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, ones, tens, hundreds, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, ten shifts per conversion,
// with saturation to 999 and registered digits that only change on completion.
module bin_to_bcd_seq #(
  parameter int W = 10
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int          EW   = (W > 10) ? W : 10;
  localparam logic [3:0]  LAST = 4'd9;

  state_t        state, state_next;
  logic [21:0]   sreg;
  logic [3:0]    cnt;
  logic          ovf_pend;
  logic          done_q;
  logic          ovf_q;
  logic [3:0]    ones_q, tens_q, hundreds_q;

  // Compare at the wider of W and 10 bits so wide inputs saturate before truncation.
  logic [EW-1:0] bin_ext;
  logic          bin_big;
  logic [9:0]    bin_sat;

  assign bin_ext = EW'(bus.bin);
  assign bin_big = (bin_ext > EW'(999));
  assign bin_sat = bin_big ? 10'd999 : bin_ext[9:0];

  // One double-dabble step: correct each BCD nibble >= 5, then shift left.
  function automatic logic [21:0] dabble(input logic [21:0] r);
    logic [21:0] t;
    t = r;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register, datapath included, is cleared so an aborted conversion leaves no trace.
    if (!reset) begin
      sreg       <= '0;
      cnt        <= '0;
      ovf_pend   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      hundreds_q <= '0;
    end else begin
      // NOTE: non-blocking throughout; every register sees pre-edge values of the others.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg     <= {12'd0, bin_sat};
            cnt      <= '0;
            ovf_pend <= bin_big;
          end
        end
        SHIFT: begin
          sreg <= dabble(sreg);
          cnt  <= cnt + 4'd1;
        end
        DONE: begin
          hundreds_q <= sreg[21:18];
          tens_q     <= sreg[17:14];
          ones_q     <= sreg[13:10];
          ovf_q      <= ovf_pend;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hundreds_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (W=16): cycle-exact timing, saturation,
// ignored starts, mid-conversion reset and a back-to-back sweep of 0..999.
module tb_bin_to_bcd_seq;

  logic clk;
  logic reset;

  bin_to_bcd_seq_if #(.W(16)) bus ();

  bin_to_bcd_seq #(.W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned last_bcd = 0;
  int unsigned last_ovf = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned digits();
    return {20'd0, bus.hundreds, bus.tens, bus.ones};
  endfunction

  function automatic int unsigned ref_bcd(input int unsigned v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Start accepted at edge k; checks busy through k+10, done/digits at k+11, done clear at k+12.
  task automatic convert(input string tag, input int unsigned val,
                         input int unsigned exp_bcd, input int unsigned exp_ovf);
    int unsigned stray;
    int unsigned busy_low;
    stray    = 0;
    busy_low = 0;
    bus.bin   = 16'(val);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_k"}, bus.busy, 1);
    check({tag, "_done_k"}, bus.done, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.done)  stray++;
      if (!bus.busy) busy_low++;
      if (c == 5) check({tag, "_hold_digits"}, digits(), last_bcd);
    end
    check({tag, "_early_done"}, stray, 0);
    check({tag, "_busy_gap"}, busy_low, 0);
    @(posedge clk); #1;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_digits"}, digits(), exp_bcd);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, bus.done, 0);
    last_bcd = exp_bcd;
    last_ovf = exp_ovf;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned stray;
    int unsigned busy_hi;

    reset     = 1'b0;
    bus.start = 1'b1;
    bus.bin   = 16'd123;

    // Reset held with start asserted: nothing may start.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_digits", digits(), 0);
      check("rst_ovf", bus.ovf, 0);
    end
    reset = 1'b1;
    convert("rst_release", 123, 'h123, 0);

    convert("basic_255", 255, 'h255, 0);
    convert("basic_0",   0,   'h000, 0);
    convert("basic_999", 999, 'h999, 0);

    convert("sat_1000",  1000,  'h999, 1);
    convert("sat_1023",  1023,  'h999, 1);
    convert("sat_65535", 65535, 'h999, 1);
    convert("clr_7",     7,     'h007, 0);

    // Starts during SHIFT (edge k+4) and during DONE (edge k+11) are dropped.
    stray     = 0;
    bus.bin   = 16'd481;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.done) stray++;
      if (c == 3)  begin bus.start = 1'b1; bus.bin = 16'd36; end
      if (c == 4)  bus.start = 1'b0;
      if (c == 10) bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_start_early_done", stray, 0);
    check("busy_start_done", bus.done, 1);
    check("busy_start_digits", digits(), 'h481);
    check("busy_start_ovf", bus.ovf, 0);
    stray   = 0;
    busy_hi = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      if (bus.done) stray++;
      if (bus.busy) busy_hi++;
    end
    check("busy_start_no_second_done", stray, 0);
    check("busy_start_not_queued", busy_hi, 0);
    last_bcd = 'h481;
    last_ovf = 0;

    // Asynchronous reset mid-conversion, between edges k+4 and k+5.
    bus.bin   = 16'd640;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_digits", digits(), 0);
    check("rst_mid_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    reset   = 1'b1;
    stray   = 0;
    busy_hi = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (bus.done) stray++;
      if (bus.busy) busy_hi++;
    end
    check("rst_mid_no_done", stray, 0);
    check("rst_mid_idle", busy_hi, 0);
    last_bcd = 0;
    last_ovf = 0;
    convert("rst_mid_again", 640, 'h640, 0);

    // Back-to-back sweep with start held high: one done every 12 cycles.
    bus.bin   = 16'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      bus.bin = 16'(i + 1);
      stray   = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (bus.done) stray++;
      end
      check("b2b_early_done", stray, 0);
      @(posedge clk); #1;
      if (i == 999) bus.start = 1'b0;
      check("b2b_done", bus.done, 1);
      check("b2b_digits", digits(), ref_bcd(i));
      check("b2b_ovf", bus.ovf, 0);
      @(posedge clk); #1;
      check("b2b_done_clr", bus.done, 0);
      check("b2b_reaccept", bus.busy, (i == 999) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment display driver. It accepts an unsigned binary value on a start strobe and runs a double-dabble (shift-and-add-3) conversion, one bit per clock. It then presents registered ones, tens and hundreds digits, each 0–9, with a one-cycle done pulse. Inputs above 999 saturate to 999 and raise an overflow flag.

## Interface
- W, 10: width of binary input `bin`; legal range 1..16.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled only in IDLE.
- bin  input  W  unsigned value to convert, sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; new digits valid from that cycle on.
- ones  output  4  BCD ones digit.
- tens  output  4  BCD tens digit.
- hundreds  output  4  BCD hundreds digit.
- ovf  output  1  high when the last accepted `bin` exceeded 999.

## Operation
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, ones=tens=hundreds=0, ovf=0, shift register and iteration counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE with start=1: load the 10-bit working value `min(bin, 999)` into the binary part of a 22-bit shift register (12-bit BCD part = 0). Set counter=0, busy=1, state=SHIFT. Latch a pending ovf = (bin > 999).
- IDLE with start=0: hold.
- SHIFT, each cycle: add 3 to every BCD nibble ≥ 5, then shift the whole 22-bit register left by 1 and increment the counter. After the 10th shift (counter reaches 9 → 10), go to DONE.
- DONE: write BCD nibbles to hundreds/tens/ones and pending ovf to ovf. Set done=1, busy=0, state=IDLE.
- done is cleared on the next edge.
- Arithmetic widths:
  - The iteration count is always 10, independent of W.
  - For W<10, bin is zero-extended to 10 bits.
  - For W>10, the compare is done at full W width before truncation.
  - The BCD part never exceeds 999, so there is no thousands digit.
- start while busy, or in the DONE cycle, is ignored. It is not queued.
- Outputs ones/tens/hundreds/ovf hold the previous result throughout a conversion. They change only in the DONE edge.
- Reset mid-conversion aborts the conversion. All outputs return to their reset values immediately, and no done pulse follows.

## Timing
- Start accepted at edge k. busy=1 from edge k.
- Shifts occur at edges k+1 … k+10.
- At edge k+11: digits and ovf are updated, done=1, busy=0.
- At edge k+12: done=0.
- Back-to-back operation: start held high, or re-asserted at edge k+12, is accepted at k+12. The earliest next done is at edge k+23, giving a throughput of one conversion per 12 cycles.
- busy is high for exactly 11 cycles per conversion.
- Consumer contract: the display driver may sample digits at any time. They are always a complete, consistent result (never partial).
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1, bin=123. Required: busy=0, done=0, digits=0/0/0, ovf=0; no conversion starts while reset is low. Release reset and check start is then accepted normally.
- Basic conversion: bin=255, start pulsed one cycle at edge k. Required: busy=1 at k..k+10, done=1 only at k+11, hundreds=2, tens=5, ones=5, ovf=0. Repeat for bin=0 (expect 0/0/0) and bin=999 (expect 9/9/9, ovf=0).
- Saturation: bin=1000, then bin=1023, then (with W=16) bin=65535. Required: 9/9/9 with ovf=1 each time. Then bin=7: 0/0/7 with ovf cleared to 0.
- Start while busy: start bin=481, then pulse start with bin=36 at k+4 and in the DONE cycle. Required: a single done at k+11 with 4/8/1. The second request is not executed, and the next done requires a fresh start in IDLE.
- Reset mid-operation: start bin=640, then assert reset at k+5 for one cycle and release. Required: outputs go to 0 immediately and no done pulse. A new start with bin=640 gives 6/4/0 after 11 cycles.
- Back-to-back: hold start=1 while sweeping bin 0..999 (one new value per accept). Required: a done every 12 cycles, and every result matches the reference decimal digits.
